hour_count_set: RTL and testbench
=================================

HOUR_COUNT_SET -- requirements
Module: hour_count_set

Interface
REQ-001 Parameter REPEAT_DELAY, default 25000000, is the number of held cycles before auto-repeat begins.
REQ-002 Parameter REPEAT_RATE, default 5000000, is the number of cycles between auto-repeat steps.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 min_carry  input  1  one-cycle pulse, synchronous to clk, asserted on minute rollover 59->00.
REQ-006 set_mode  input  1  asynchronous level from a switch; high selects hour-setting mode.
REQ-007 inc_btn  input  1  asynchronous level from a push button; high means pressed, increment hour.
REQ-008 dec_btn  input  1  asynchronous level from a push button; high means pressed, decrement hour.
REQ-009 times  output  5  registered hour value, binary, range 0-23, feeding the hour seven-segment decoder.
REQ-010 day_carry  output  1  registered one-cycle pulse on the 23->0 wrap in RUN.
REQ-011 set_active  output  1  registered; high while FSM is not in RUN.

Function
REQ-012 set_mode, inc_btn and dec_btn SHALL each pass a 2-flop synchronizer, then a third flop for edge detection (rise = s2 & ~s3).
REQ-013 A button sampled high at edge k SHALL produce its single step on times after edge k+2 (2-cycle latency).
REQ-014 FSM states SHALL be RUN, SET, HOLD_INC and HOLD_DEC.
REQ-015 RUN->SET SHALL occur when synchronized set_mode is 1; any state other than RUN SHALL go to RUN when synchronized set_mode is 0.
REQ-016 In RUN, min_carry=1 SHALL increment times by 1; 23->0 SHALL assert day_carry for exactly the cycle times becomes 0.
REQ-017 In RUN, inc_btn and dec_btn SHALL be ignored.
REQ-018 Outside RUN, min_carry SHALL be ignored and discarded (no catch-up on exit); day_carry SHALL stay 0.
REQ-019 In SET, an inc rise alone SHALL step times +1 (23->0) and go to HOLD_INC; a dec rise alone SHALL step times -1 (0->23) and go to HOLD_DEC.
REQ-020 Simultaneous inc and dec rises in SET SHALL leave times unchanged and keep the FSM in SET.
REQ-021 In HOLD_x, the repeat counter SHALL count cycles while the synchronized button is held.
REQ-022 The first repeat step SHALL occur REPEAT_DELAY cycles after the initial step.
REQ-023 Each later repeat step SHALL occur every REPEAT_RATE cycles, with the same wrap rules as REQ-019.
REQ-024 Release of the held button, or assertion of the opposite button, SHALL return the FSM to SET, clear the repeat counter and cause no step.
REQ-025 The repeat counter SHALL be wide enough for max(REPEAT_DELAY, REPEAT_RATE) and SHALL never wrap.
REQ-026 times SHALL never hold a value >23; an illegal value SHALL be forced to 0 on the next edge.
REQ-027 set_active SHALL be 1 in the cycle after the FSM leaves RUN and 0 in the cycle after it returns.
REQ-028 On the edge where set_mode falls, a coincident min_carry SHALL be ignored; RUN counting SHALL resume on the following cycle.

Reset
REQ-029 reset=1 at an edge SHALL set times=0, day_carry=0, set_active=0, FSM=RUN, synchronizer/edge flops=0 and repeat counter=0.
REQ-030 reset SHALL override every other input in the same cycle, including mid-hold and mid-wrap.
REQ-031 After reset deasserts, a button already held SHALL NOT produce a step until released and pressed again.

Verification
REQ-032 RUN wrap: times=22, two min_carry pulses -> times 23 then 0; day_carry high exactly one cycle coincident with 0.
REQ-033 SET dec wrap: set_mode=1, times=0, single dec press -> times=23 two cycles after sampling; day_carry stays 0.
REQ-034 Auto-repeat with REPEAT_DELAY=10, REPEAT_RATE=4: inc held 30 cycles from times=5 -> steps at press+2, +12, +16, +20, +24, +28, final times=11.
REQ-035 Simultaneous inc and dec pressed in SET -> times unchanged; FSM stays SET; no repeat.
REQ-036 min_carry pulses during SET -> times unchanged; after set_mode falls, the next pulse increments by 1.
REQ-037 reset asserted mid HOLD_INC at times=17 -> next cycle times=0, set_active=0; held inc with set_mode=1 gives no step until released and re-pressed.

Source files
------------

// File: rtl/hour_count_set.sv
// rtl/hour_count_set.sv - hour counter (0-23) with run/set modes and button auto-repeat
module hour_count_set #(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       min_carry,
    input  logic       set_mode,
    input  logic       inc_btn,
    input  logic       dec_btn,
    output logic [4:0] times,
    output logic       day_carry,
    output logic       set_active
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_TOP    = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET      = 2'd1,
        HOLD_INC = 2'd2,
        HOLD_DEC = 2'd3
    } state_t;

    state_t state, state_next;

    // set_mode is consumed only as a level, so it stops at the second flop.
    logic       mode_s1, mode_s2;
    // Bit 0 = inc, bit 1 = dec.
    logic [1:0] btn_s1, btn_s2, btn_s3;
    logic [1:0] armed;
    logic [1:0] warm;
    logic [1:0] btn_rise;

    logic [CNT_W-1:0] cnt, cnt_next;
    logic             repeating, repeating_next;
    logic [4:0]       times_next;
    logic             carry_next;

    logic held_lvl, opp_lvl, hold_up;

    function automatic logic [4:0] hour_up(input logic [4:0] h);
        return (h >= 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    function automatic logic [4:0] hour_down(input logic [4:0] h);
        return (h == 5'd0 || h > 5'd23) ? 5'd23 : h - 5'd1;
    endfunction

    // A button held through reset stays disarmed until it is seen released,
    // once the synchronizers have refilled after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_s1 <= 1'b0;
            mode_s2 <= 1'b0;
            btn_s1  <= 2'b00;
            btn_s2  <= 2'b00;
            btn_s3  <= 2'b00;
            armed   <= 2'b00;
            warm    <= 2'b00;
        end else begin
            mode_s1 <= set_mode;
            mode_s2 <= mode_s1;
            btn_s1  <= {dec_btn, inc_btn};
            btn_s2  <= btn_s1;
            btn_s3  <= btn_s2;
            warm    <= {warm[0], 1'b1};
            armed   <= armed | ({2{warm[1]}} & ~btn_s2);
        end
    end

    assign btn_rise = btn_s2 & ~btn_s3 & armed;

    assign hold_up  = (state == HOLD_INC);
    assign held_lvl = hold_up ? btn_s2[0] : btn_s2[1];
    assign opp_lvl  = hold_up ? btn_s2[1] : btn_s2[0];

    always_comb begin
        state_next     = state;
        times_next     = times;
        cnt_next       = cnt;
        repeating_next = repeating;
        carry_next     = 1'b0;

        case (state)
            RUN: begin
                cnt_next       = '0;
                repeating_next = 1'b0;
                if (mode_s2) begin
                    state_next = SET;
                end else if (min_carry) begin
                    times_next = hour_up(times);
                    carry_next = (times == 5'd23);
                end
            end
            SET: begin
                cnt_next       = '0;
                repeating_next = 1'b0;
                if (!mode_s2) begin
                    state_next = RUN;
                end else if (btn_rise == 2'b01) begin
                    times_next = hour_up(times);
                    state_next = HOLD_INC;
                end else if (btn_rise == 2'b10) begin
                    times_next = hour_down(times);
                    state_next = HOLD_DEC;
                end
            end
            default: begin
                if (!mode_s2) begin
                    state_next     = RUN;
                    cnt_next       = '0;
                    repeating_next = 1'b0;
                end else if (!held_lvl || opp_lvl) begin
                    state_next     = SET;
                    cnt_next       = '0;
                    repeating_next = 1'b0;
                end else if (cnt == (repeating ? RATE_LAST : DELAY_LAST)) begin
                    times_next     = hold_up ? hour_up(times) : hour_down(times);
                    cnt_next       = '0;
                    repeating_next = 1'b1;
                end else if (cnt < CNT_TOP) begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase

        if (times > 5'd23) begin
            times_next = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            times      <= 5'd0;
            day_carry  <= 1'b0;
            set_active <= 1'b0;
            cnt        <= '0;
            repeating  <= 1'b0;
        end else begin
            state      <= state_next;
            times      <= times_next;
            day_carry  <= carry_next;
            set_active <= (state_next != RUN);
            cnt        <= cnt_next;
            repeating  <= repeating_next;
        end
    end

endmodule

// File: tb/tb_hour_count_set.sv
// tb/tb_hour_count_set.sv - scoreboard bench for hour_count_set
module tb_hour_count_set;

    logic       clk = 1'b0;
    logic       reset;
    logic       min_carry;
    logic       set_mode;
    logic       inc_btn;
    logic       dec_btn;
    logic [4:0] times;
    logic       day_carry;
    logic       set_active;

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_q[$];
    logic       mon_en = 1'b0;
    logic [4:0] prev_t;

    hour_count_set #(.REPEAT_DELAY(10), .REPEAT_RATE(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .min_carry (min_carry),
        .set_mode  (set_mode),
        .inc_btn   (inc_btn),
        .dec_btn   (dec_btn),
        .times     (times),
        .day_carry (day_carry),
        .set_active(set_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Any change of times, or any day_carry, is an output event to be matched.
    always @(negedge clk) begin
        if (mon_en && (times !== prev_t || day_carry !== 1'b0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: got times=%0d carry=%0b expected none", times, day_carry);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("event_times", int'(times), int'(e[4:0]));
                check("event_carry", int'(day_carry), int'(e[5]));
            end
        end
        prev_t = times;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_hour(input int t, input logic c);
        exp_q.push_back({c, 5'(t)});
    endtask

    task automatic pulse_carry();
        min_carry = 1'b1;
        cyc(1);
        min_carry = 1'b0;
        cyc(1);
    endtask

    task automatic press(input logic up);
        if (up) inc_btn = 1'b1; else dec_btn = 1'b1;
        cyc(2);
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset = 1'b1; min_carry = 1'b0; set_mode = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
        cyc(3);
        reset = 1'b0;
        check("reset_times", int'(times), 0);
        check("reset_carry", int'(day_carry), 0);
        check("reset_set_active", int'(set_active), 0);
        prev_t = times;
        mon_en = 1'b1;
        cyc(4);

        // Buttons are ignored in RUN.
        press(1'b1);
        press(1'b0);

        // Count up to 22, then wrap through 23 to 0 with one carry.
        for (int i = 1; i <= 22; i++) begin
            expect_hour(i, 1'b0);
            pulse_carry();
        end
        expect_hour(23, 1'b0);
        pulse_carry();
        expect_hour(0, 1'b1);
        pulse_carry();
        cyc(3);
        check("run_wrap_times", int'(times), 0);

        set_mode = 1'b1;
        cyc(4);
        check("set_active_on", int'(set_active), 1);

        // Dec wrap 0 -> 23, two-edge latency.
        expect_hour(23, 1'b0);
        dec_btn = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("dec_latency_k1", int'(times), 0);
        @(posedge clk); #1;
        check("dec_latency_k2", int'(times), 23);
        dec_btn = 1'b0;
        cyc(4);

        // Inc wrap 23 -> 0 in SET gives no carry, then walk up to 5.
        for (int i = 0; i <= 5; i++) begin
            expect_hour(i, 1'b0);
            press(1'b1);
        end

        // Auto-repeat: 30 held cycles from 5.
        for (int i = 6; i <= 11; i++) expect_hour(i, 1'b0);
        inc_btn = 1'b1;
        cyc(12);
        check("repeat_before_first", int'(times), 6);
        cyc(1);
        check("repeat_first", int'(times), 7);
        cyc(17);
        inc_btn = 1'b0;
        cyc(6);
        check("repeat_final", int'(times), 11);

        // Simultaneous presses: no step, FSM stays in SET.
        inc_btn = 1'b1; dec_btn = 1'b1;
        cyc(3);
        inc_btn = 1'b0; dec_btn = 1'b0;
        cyc(4);
        check("both_pressed", int'(times), 11);
        expect_hour(12, 1'b0);
        press(1'b1);

        // Opposite button during hold aborts without a step.
        expect_hour(13, 1'b0);
        inc_btn = 1'b1;
        cyc(5);
        dec_btn = 1'b1;
        cyc(3);
        inc_btn = 1'b0; dec_btn = 1'b0;
        cyc(4);
        check("opposite_abort", int'(times), 13);

        // min_carry ignored in SET, honoured after leaving it.
        pulse_carry();
        pulse_carry();
        pulse_carry();
        check("set_ignores_carry", int'(times), 13);
        set_mode = 1'b0;
        cyc(4);
        check("set_active_off", int'(set_active), 0);
        expect_hour(14, 1'b0);
        pulse_carry();

        // Reset during HOLD_INC at 17; held button must not step afterwards.
        set_mode = 1'b1;
        cyc(4);
        expect_hour(15, 1'b0);
        press(1'b1);
        expect_hour(16, 1'b0);
        press(1'b1);
        expect_hour(17, 1'b0);
        inc_btn = 1'b1;
        cyc(5);
        check("pre_reset_times", int'(times), 17);
        expect_hour(0, 1'b0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("hold_reset_times", int'(times), 0);
        check("hold_reset_set_active", int'(set_active), 0);
        cyc(25);
        check("held_after_reset", int'(times), 0);
        check("set_after_reset", int'(set_active), 1);
        inc_btn = 1'b0;
        cyc(4);
        expect_hour(1, 1'b0);
        press(1'b1);
        cyc(4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
